// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer read path: FSM encoding,
// buffer-in-use codes and default frame geometry.
package vga_pkg;

  localparam int IMG_W_DEFAULT = 400;
  localparam int IMG_H_DEFAULT = 320;

  localparam logic [1:0] STATE_NONE = 2'b00;
  localparam logic [1:0] STATE_BUF0 = 2'b01;
  localparam logic [1:0] STATE_BUF1 = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_RELEASE
  } fsm_t;

  // The buffer-in-use code doubles as the one-hot release mask.
  function automatic logic [1:0] buf_code(input logic b);
    return b ? STATE_BUF1 : STATE_BUF0;
  endfunction

endpackage

// File: rtl/vga_buf_pick.sv
// Ping-pong buffer choice: alternate when both frames are ready,
// otherwise take whichever one is.
module vga_buf_pick (
  input  logic [1:0] buf_ready,
  input  logic       last_buf,
  output logic       valid,
  output logic       pick
);

  assign valid = |buf_ready;
  assign pick  = (buf_ready == 2'b11) ? ~last_buf : buf_ready[1];

endmodule

// File: rtl/vga_frame_rd_sched.sv
// Read-side scheduler: selects a ready frame buffer, streams it into the
// pixel FIFO as fixed-size DDR3 bursts and hands it back at end of frame.
module vga_frame_rd_sched
  import vga_pkg::*;
#(
  parameter int                IMG_W      = IMG_W_DEFAULT,
  parameter int                IMG_H      = IMG_H_DEFAULT,
  parameter int                BURST_LEN  = 64,
  parameter int                FIFO_DEPTH = 1024,
  parameter int                ADDR_W     = 28,
  parameter logic [ADDR_W-1:0] BUF0_BASE  = 'h0,
  parameter logic [ADDR_W-1:0] BUF1_BASE  = 'h40000
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic              ip_enable,
  input  logic [1:0]        buf_ready,
  input  logic              img_end,
  input  logic [9:0]        fifo_usedw,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic [1:0]        state,
  output logic [1:0]        buf_release,
  output logic [10:0]       burst_num,
  output logic              frame_err
);

  localparam int          NBURST   = IMG_W * IMG_H / BURST_LEN;
  localparam logic [10:0] NBURST_C = 11'(NBURST);
  localparam logic [9:0]  FIFO_THR = 10'(FIFO_DEPTH - BURST_LEN);

  fsm_t              fsm;
  logic              last_buf;
  logic              sel;
  logic              abort;
  logic [ADDR_W-1:0] base;

  logic              pick_valid;
  logic              pick;

  vga_buf_pick u_pick (
    .buf_ready (buf_ready),
    .last_buf  (last_buf),
    .valid     (pick_valid),
    .pick      (pick)
  );

  logic [10:0]       burst_inc;
  logic [10:0]       done_cnt;
  logic              stop;
  fsm_t              done_next;
  logic [ADDR_W-1:0] burst_addr;

  // A done seen together with an ack in REQ counts the burst being acked.
  always_comb begin
    burst_inc  = burst_num + 11'd1;
    done_cnt   = (fsm == S_WAIT) ? burst_num : burst_inc;
    stop       = abort || !ip_enable;
    done_next  = stop ? S_IDLE : ((done_cnt == NBURST_C) ? S_DRAIN : S_REQ);
    burst_addr = base + ADDR_W'(burst_num) * ADDR_W'(BURST_LEN);
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= S_IDLE;
      last_buf    <= 1'b1;
      sel         <= 1'b0;
      abort       <= 1'b0;
      base        <= '0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      state       <= STATE_NONE;
      buf_release <= 2'b00;
      burst_num   <= '0;
      frame_err   <= 1'b0;
    end else begin
      buf_release <= 2'b00;
      if ((fsm == S_REQ || fsm == S_WAIT) && img_end) frame_err <= 1'b1;

      case (fsm)
        S_IDLE: begin
          abort <= 1'b0;
          if (ip_enable) fsm <= S_SELECT;
        end
        S_SELECT: begin
          if (!ip_enable) begin
            fsm <= S_IDLE;
          end else if (pick_valid) begin
            sel       <= pick;
            last_buf  <= pick;
            state     <= buf_code(pick);
            base      <= pick ? BUF1_BASE : BUF0_BASE;
            burst_num <= '0;
            frame_err <= 1'b0;
            fsm       <= S_REQ;
          end
        end
        S_REQ: begin
          if (rd_req && rd_ack) begin
            rd_req    <= 1'b0;
            burst_num <= burst_inc;
            if (rd_done) begin
              fsm <= done_next;
              if (stop) state <= STATE_NONE;
            end else begin
              fsm <= S_WAIT;
            end
          end else if (!ip_enable) begin
            // Abandon an un-acked request outright; the DDR3 side copes.
            rd_req <= 1'b0;
            state  <= STATE_NONE;
            fsm    <= S_IDLE;
          end else if (!rd_req && fifo_usedw < FIFO_THR) begin
            rd_req  <= 1'b1;
            rd_addr <= burst_addr;
          end
        end
        S_WAIT: begin
          if (!ip_enable) abort <= 1'b1;
          if (rd_done) begin
            abort <= 1'b0;
            fsm   <= done_next;
            if (stop) state <= STATE_NONE;
          end
        end
        S_DRAIN: begin
          if (img_end) begin
            buf_release <= buf_code(sel);
            state       <= STATE_NONE;
            fsm         <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          fsm <= ip_enable ? S_SELECT : S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_rd_sched.sv
// Directed bench for vga_frame_rd_sched: throttling, buffer choice,
// full-frame burst sequencing, early img_end, disable and reset paths.
module tb_vga_frame_rd_sched;

  logic        vga_clk = 1'b0;
  logic        rst_n;
  logic        ip_enable;
  logic [1:0]  buf_ready;
  logic        img_end;
  logic [9:0]  fifo_usedw;
  logic        rd_req;
  logic [27:0] rd_addr;
  logic        rd_ack;
  logic        rd_done;
  logic [1:0]  state;
  logic [1:0]  buf_release;
  logic [10:0] burst_num;
  logic        frame_err;

  int n_chk  = 0;
  int n_fail = 0;

  vga_frame_rd_sched dut (
    .vga_clk     (vga_clk),
    .rst_n       (rst_n),
    .ip_enable   (ip_enable),
    .buf_ready   (buf_ready),
    .img_end     (img_end),
    .fifo_usedw  (fifo_usedw),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_ack      (rd_ack),
    .rd_done     (rd_done),
    .state       (state),
    .buf_release (buf_release),
    .burst_num   (burst_num),
    .frame_err   (frame_err)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic wait_req(output logic ok);
    int n;
    n = 0;
    while (rd_req !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    ok = (rd_req === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ip_enable = 1'b0; buf_ready = 2'b00; img_end = 1'b0;
    fifo_usedw = 10'd0; rd_ack = 1'b0; rd_done = 1'b0;
    repeat (3) tick();
    n_chk++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_rd_req: got %b want 0", rd_req); end
    n_chk++; if (rd_addr !== 28'h0) begin n_fail++; $display("FAIL reset_rd_addr: got %h want 0", rd_addr); end
    n_chk++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", state); end
    n_chk++; if (buf_release !== 2'b00) begin n_fail++; $display("FAIL reset_release: got %b want 00", buf_release); end
    n_chk++; if (burst_num !== 11'd0) begin n_fail++; $display("FAIL reset_burst_num: got %0d want 0", burst_num); end
    n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fifo_throttle();
    int bad;
    bad = 0;
    fifo_usedw = 10'd960; buf_ready = 2'b01; ip_enable = 1'b1;
    repeat (20) begin tick(); if (rd_req !== 1'b0) bad++; end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL throttle_hold: rd_req high %0d cycles want 0", bad); end
    n_chk++; if (state !== 2'b01) begin n_fail++; $display("FAIL throttle_state: got %b want 01", state); end
    fifo_usedw = 10'd959;
    tick();
    n_chk++; if (rd_req !== 1'b1 || rd_addr !== 28'h0) begin
      n_fail++; $display("FAIL throttle_rise: rd_req %b addr %h want 1 / 0", rd_req, rd_addr); end
    fifo_usedw = 10'd1023;
    bad = 0;
    repeat (3) begin tick(); if (rd_req !== 1'b1 || rd_addr !== 28'h0) bad++; end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL req_committed: dropped/moved %0d cycles want 0", bad); end
    ip_enable = 1'b0; fifo_usedw = 10'd0;
    tick();
    n_chk++; if (rd_req !== 1'b0 || state !== 2'b00 || burst_num !== 11'd0) begin
      n_fail++; $display("FAIL disable_in_req: req %b state %b bn %0d want 0/00/0", rd_req, state, burst_num); end
  endtask

  task automatic test_select_wait();
    int bad;
    logic ok;
    bad = 0;
    buf_ready = 2'b00; ip_enable = 1'b1;
    repeat (100) begin tick(); if (state !== 2'b00 || rd_req !== 1'b0) bad++; end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL select_idle: %0d active cycles want 0", bad); end
    buf_ready = 2'b10;
    tick();
    n_chk++; if (state !== 2'b10) begin n_fail++; $display("FAIL select_buf1: state %b want 10", state); end
    wait_req(ok);
    n_chk++; if (!ok || rd_addr !== 28'h40000) begin
      n_fail++; $display("FAIL buf1_addr: req %b addr %h want 1 / 0040000", rd_req, rd_addr); end
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    ip_enable = 1'b0;
    repeat (5) tick();
    n_chk++; if (state !== 2'b10 || rd_req !== 1'b0) begin
      n_fail++; $display("FAIL wait_hold: state %b req %b want 10 / 0", state, rd_req); end
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    n_chk++; if (state !== 2'b00 || buf_release !== 2'b00 || burst_num !== 11'd1) begin
      n_fail++; $display("FAIL wait_abort: state %b rel %b bn %0d want 00/00/1", state, buf_release, burst_num); end
    bad = 0;
    repeat (3) begin tick(); if (rd_req !== 1'b0 || buf_release !== 2'b00) bad++; end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL abort_quiet: %0d active cycles want 0", bad); end
    buf_ready = 2'b00;
  endtask

  task automatic test_ack_done_same();
    logic ok;
    buf_ready = 2'b01; ip_enable = 1'b1;
    wait_req(ok);
    n_chk++; if (!ok || rd_addr !== 28'h0 || state !== 2'b01) begin
      n_fail++; $display("FAIL ackdone_first: req %b addr %h state %b want 1/0/01", rd_req, rd_addr, state); end
    rd_ack = 1'b1; rd_done = 1'b1; tick(); rd_ack = 1'b0; rd_done = 1'b0;
    n_chk++; if (rd_req !== 1'b0 || burst_num !== 11'd1) begin
      n_fail++; $display("FAIL ackdone_count: req %b bn %0d want 0 / 1", rd_req, burst_num); end
    wait_req(ok);
    n_chk++; if (!ok || rd_addr !== 28'd64) begin
      n_fail++; $display("FAIL ackdone_next: req %b addr %h want 1 / 0000040", rd_req, rd_addr); end
    ip_enable = 1'b0;
    tick();
    n_chk++; if (rd_req !== 1'b0 || state !== 2'b00) begin
      n_fail++; $display("FAIL ackdone_abandon: req %b state %b want 0 / 00", rd_req, state); end
    buf_ready = 2'b00;
  endtask

  task automatic test_async_reset();
    logic ok;
    buf_ready = 2'b11; ip_enable = 1'b1;
    wait_req(ok);
    n_chk++; if (!ok || rd_addr !== 28'h40000) begin
      n_fail++; $display("FAIL rst_setup: req %b addr %h want 1 / 0040000", rd_req, rd_addr); end
    #3 rst_n = 1'b0;
    #1;
    n_chk++; if (rd_req !== 1'b0 || rd_addr !== 28'h0 || state !== 2'b00 || burst_num !== 11'd0) begin
      n_fail++; $display("FAIL async_reset: req %b addr %h state %b bn %0d want all 0", rd_req, rd_addr, state, burst_num); end
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic run_frame(input string nm, input logic [27:0] base_exp, input logic [1:0] st_exp,
                           input int ack_dly, input int done_dly, input int err_at,
                           input logic [1:0] next_exp);
    int bad;
    logic ok;
    logic [27:0] a, fa, fe;
    bad = 0; fa = '0; fe = '0;
    for (int k = 0; k < 2000; k++) begin
      a = base_exp + 28'(k * 64);
      wait_req(ok);
      if (!ok) begin
        n_chk++; n_fail++;
        $display("FAIL %s_req_timeout: burst %0d rd_req 0 want 1", nm, k);
        return;
      end
      if (rd_addr !== a && bad == 0) begin fa = rd_addr; fe = a; end
      if (rd_addr !== a || state !== st_exp) bad++;
      repeat (ack_dly) begin tick(); if (rd_req !== 1'b1 || rd_addr !== a) bad++; end
      rd_ack = 1'b1; tick(); rd_ack = 1'b0;
      if (rd_req !== 1'b0 || burst_num !== 11'(k + 1)) bad++;
      for (int i = 0; i < done_dly; i++) begin
        img_end = (k + 1 == err_at) && (i == 0);
        tick();
      end
      img_end = 1'b0;
      if (k + 1 == err_at) begin
        n_chk++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL %s_err_set: frame_err %b want 1", nm, frame_err); end
      end
      rd_done = 1'b1; tick(); rd_done = 1'b0;
    end
    n_chk++; if (bad != 0) begin
      n_fail++; $display("FAIL %s_bursts: %0d bad cycles, first addr %h want %h", nm, bad, fa, fe); end
    bad = 0;
    repeat (10) begin tick(); if (rd_req !== 1'b0 || burst_num !== 11'd2000) bad++; end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL %s_drain: %0d bad cycles want 0", nm, bad); end
    n_chk++; if (state !== st_exp) begin n_fail++; $display("FAIL %s_drain_state: %b want %b", nm, state, st_exp); end
    n_chk++; if (frame_err !== (err_at != 0)) begin
      n_fail++; $display("FAIL %s_frame_err: %b want %b", nm, frame_err, (err_at != 0)); end
    img_end = 1'b1; tick(); img_end = 1'b0;
    n_chk++; if (buf_release !== st_exp || state !== 2'b00) begin
      n_fail++; $display("FAIL %s_release: rel %b state %b want %b / 00", nm, buf_release, state, st_exp); end
    tick();
    n_chk++; if (buf_release !== 2'b00) begin n_fail++; $display("FAIL %s_release_pulse: %b want 00", nm, buf_release); end
    tick();
    n_chk++; if (state !== next_exp || burst_num !== 11'd0) begin
      n_fail++; $display("FAIL %s_next: state %b bn %0d want %b / 0", nm, state, burst_num, next_exp); end
  endtask

  initial begin
    test_reset();
    test_fifo_throttle();
    test_select_wait();
    test_ack_done_same();
    test_async_reset();
    run_frame("frame0", 28'h0, 2'b01, 0, 19, 0, 2'b10);
    run_frame("frame1", 28'h40000, 2'b10, 1, 2, 500, 2'b01);
    n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: frame_err %b want 0", frame_err); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
